counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Control-plane sequencer for the 5-bit counter datapath. Conditions four raw pushbuttons
//  and runs a LOAD/PAUSED/RUN state machine that drives the counter's set, pause and
//  count-direction controls and the display-type select. An optional auto-demo scheduler
//  alternates increment and shift-left every DemoTicks counter steps.
//  Sits between board buttons and counter / multiplexer, in the 50 MHz domain.
// PARAMETERS
//  DebounceCycles  4   clocks an input must be stable before its debounced level changes (>=1)
//  DemoTicks       32  i_tick pulses per auto-demo phase before o_count toggles (>=1)
// PORTS
//  i_clk       in   1  system clock, 50 MHz
//  i_reset     in   1  synchronous reset, active-low
//  i_tick      in   1  1-cycle step strobe from clock divider; counter samples controls on it
//  i_btn_run   in   1  raw button, active-high: toggle run/pause
//  i_btn_load  in   1  raw button, active-high: reload Initial value
//  i_btn_mode  in   1  raw button, active-high: toggle increment / shift-left
//  i_btn_disp  in   1  raw button, active-high: toggle BIN / DEC display
//  i_auto      in   1  level: auto-demo enable
//  o_set       out  1  to counter i_set
//  o_pause     out  1  to counter i_pause
//  o_count     out  1  to counter i_count (1 = increment, 0 = shift-left)
//  o_type      out  1  to multiplexer i_type (1 = DEC, 0 = BIN)
//  o_state     out  2  00 PAUSED, 01 RUN, 10 LOAD (11 unused)
//  o_busy      out  1  high while in LOAD
// BEHAVIOUR
//  Reset (i_reset==0 at a clock edge): state=LOAD, o_count=1, o_type=0, all synchronisers,
//   debounce and demo counters cleared, debounced levels = 0. All outputs are registered.
//  Input conditioning, per button:
//   - 2-flop synchroniser.
//   - Debounce counter: debounced level takes the synced value after DebounceCycles
//     consecutive clocks of it differing from the current level. Any mismatch-free
//     cycle clears the count.
//   - Press = 1-cycle pulse on the debounced rising edge. Release generates nothing.
//   - Total latency raw edge -> press pulse: 2 + DebounceCycles + 1 clocks.
//  FSM:
//   - LOAD: o_set=1, o_pause=1. Held until an i_tick is seen (so the slow counter samples
//     it), then PAUSED next cycle. Presses of run/load in LOAD are ignored.
//   - PAUSED: o_set=0, o_pause=1. run press -> RUN; load press -> LOAD.
//   - RUN: o_set=0, o_pause=0. run press -> PAUSED; load press -> LOAD.
//   - Same-cycle run+load press: load wins.
//  Toggles: mode press toggles o_count and disp press toggles o_type in any state, including
//   LOAD. Output changes the cycle after the pulse. Independent of FSM priority.
//  Auto-demo:
//   - Demo counter, width $clog2(DemoTicks+1), increments on i_tick only when state==RUN and
//     i_auto==1.
//   - On the tick that brings it to DemoTicks: o_count toggles and counter returns to 0.
//   - Counter clears when leaving RUN, when i_auto==0, or on a mode press.
//   - Same-cycle mode press and demo expiry: single toggle.
//  Reset mid-operation: immediate return to reset values regardless of state or counts.
// TESTING (DebounceCycles=4, DemoTicks=4, i_tick every 8 clocks)
//  1. Release reset, no buttons -> o_state=10, o_set=1 until first i_tick; then o_state=00,
//     o_set=0, o_pause=1, o_count=1, o_type=0.
//  2. Pulse i_btn_run high for 3 clocks -> no state change (bounce rejected); hold 10 clocks
//     -> o_state=01, o_pause=0 exactly 8 clocks after the rising edge.
//  3. In RUN, press run and load in the same cycle -> o_state=10, o_set=1; after next
//     i_tick -> o_state=00.
//  4. RUN with i_auto=1 -> o_count toggles 1->0 on the 4th i_tick, 0->1 on the 8th; drop
//     i_auto after 2 ticks, re-raise -> next toggle needs 4 fresh ticks.
//  5. Press disp, then mode, while in LOAD -> o_type=1, o_count=0; FSM still exits LOAD on
//     i_tick.
//  6. Assert i_reset=0 for 1 clock while in RUN mid-demo -> all outputs at reset values
//     next cycle, demo count 0.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between board-side stimulus and the counter sequencer.
// master drives tick, buttons and auto-enable; slave (the sequencer) returns counter/mux controls.
interface counter_sequencer_if;
  logic       i_tick;
  logic       i_btn_run;
  logic       i_btn_load;
  logic       i_btn_mode;
  logic       i_btn_disp;
  logic       i_auto;
  logic       o_set;
  logic       o_pause;
  logic       o_count;
  logic       o_type;
  logic [1:0] o_state;
  logic       o_busy;

  modport master (
    output i_tick, i_btn_run, i_btn_load, i_btn_mode, i_btn_disp, i_auto,
    input  o_set, o_pause, o_count, o_type, o_state, o_busy
  );

  modport slave (
    input  i_tick, i_btn_run, i_btn_load, i_btn_mode, i_btn_disp, i_auto,
    output o_set, o_pause, o_count, o_type, o_state, o_busy
  );
endinterface

// File: rtl/counter_sequencer.sv
// Button conditioning + LOAD/PAUSED/RUN sequencer with auto-demo; button edge to press 2+DebounceCycles+1 clk,
// state/toggle outputs one clock after the press; no backpressure, every press and tick is acted on.
module counter_sequencer #(
  parameter int DebounceCycles = 4,
  parameter int DemoTicks      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  counter_sequencer_if.slave   bus
);

  localparam int DbW   = $clog2(DebounceCycles + 1);
  localparam int DemoW = $clog2(DemoTicks + 1);
  localparam logic [DbW-1:0]   DB_LAST   = DbW'(DebounceCycles - 1);
  localparam logic [DemoW-1:0] DEMO_LAST = DemoW'(DemoTicks - 1);

  localparam int BTN_RUN  = 0;
  localparam int BTN_LOAD = 1;
  localparam int BTN_MODE = 2;
  localparam int BTN_DISP = 3;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'b00,
    ST_RUN    = 2'b01,
    ST_LOAD   = 2'b10
  } state_t;

  logic [3:0]     raw;
  logic [3:0]     sync1;
  logic [3:0]     sync2;
  logic [3:0]     db;
  logic [3:0]     db_prev;
  logic [3:0]     press;
  logic [DbW-1:0] db_cnt [4];

  state_t     state;
  state_t     state_nxt;
  logic       set_nxt;
  logic       pause_nxt;
  logic       set_q;
  logic       pause_q;
  logic       busy_q;

  logic [DemoW-1:0] demo_cnt;
  logic             demo_exp;
  logic             count_q;
  logic             type_q;

  assign raw = {bus.i_btn_disp, bus.i_btn_mode, bus.i_btn_load, bus.i_btn_run};

  // Press is registered from the debounced rising edge, giving 2 + DebounceCycles + 1 clocks of latency.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      press   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      press   <= db & ~db_prev;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DbW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= ST_LOAD;
      set_q   <= 1'b1;
      pause_q <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state   <= state_nxt;
      set_q   <= set_nxt;
      pause_q <= pause_nxt;
      busy_q  <= set_nxt;
    end
  end

  // LOAD is held until the slow counter has seen a tick; load beats run when both press together.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:   if (bus.i_tick) state_nxt = ST_PAUSED;
      ST_PAUSED: begin
        if (press[BTN_LOAD])     state_nxt = ST_LOAD;
        else if (press[BTN_RUN]) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (press[BTN_LOAD])     state_nxt = ST_LOAD;
        else if (press[BTN_RUN]) state_nxt = ST_PAUSED;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    set_nxt   = (state_nxt == ST_LOAD);
    pause_nxt = (state_nxt != ST_RUN);
  end

  assign demo_exp = bus.i_tick && (state == ST_RUN) && bus.i_auto && (demo_cnt == DEMO_LAST);

  // A mode press coinciding with demo expiry yields a single toggle.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      demo_cnt <= '0;
      count_q  <= 1'b1;
      type_q   <= 1'b0;
    end else begin
      if (press[BTN_MODE] || (state != ST_RUN) || !bus.i_auto || demo_exp)
        demo_cnt <= '0;
      else if (bus.i_tick)
        demo_cnt <= demo_cnt + DemoW'(1);
      count_q <= count_q ^ (press[BTN_MODE] | demo_exp);
      type_q  <= type_q ^ press[BTN_DISP];
    end
  end

  assign bus.o_set   = set_q;
  assign bus.o_pause = pause_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_state = state;
  assign bus.o_count = count_q;
  assign bus.o_type  = type_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: DebounceCycles=4, DemoTicks=4, tick every 8 clocks.
module tb_counter_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       tick_en;
  logic       auto_en;
  logic [3:0] btn;
  int         tick_ctr;
  int         vectors;
  int         miscompares;

  counter_sequencer_if bif ();

  assign bif.i_tick     = tick;
  assign bif.i_btn_run  = btn[0];
  assign bif.i_btn_load = btn[1];
  assign bif.i_btn_mode = btn[2];
  assign bif.i_btn_disp = btn[3];
  assign bif.i_auto     = auto_en;

  counter_sequencer #(
    .DebounceCycles (4),
    .DemoTicks      (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick     = 1'b0;
    tick_ctr = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_ctr++;
      tick = tick_en && (tick_ctr % 8 == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Returns at the falling edge right after the clock edge that sampled the next tick.
  task automatic wait_tick();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (tick) break;
    end
    @(negedge clk);
  endtask

  task automatic press_btns(input logic [3:0] v);
    @(posedge clk);
    #1 btn = v;
    repeat (10) @(posedge clk);
    #1 btn = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL rst_state: got %b expected 10", bif.o_state); end
    if (bif.o_set   !== 1'b1)  begin miscompares++; $display("FAIL rst_set: got %b expected 1", bif.o_set); end
    if (bif.o_pause !== 1'b1)  begin miscompares++; $display("FAIL rst_pause: got %b expected 1", bif.o_pause); end
    if (bif.o_count !== 1'b1)  begin miscompares++; $display("FAIL rst_count: got %b expected 1", bif.o_count); end
    if (bif.o_type  !== 1'b0)  begin miscompares++; $display("FAIL rst_type: got %b expected 0", bif.o_type); end
    if (bif.o_busy  !== 1'b1)  begin miscompares++; $display("FAIL rst_busy: got %b expected 1", bif.o_busy); end
    rst_n   = 1'b1;
    tick_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tick) break;
    end
    vectors += 2;
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL load_hold_state: got %b expected 10", bif.o_state); end
    if (bif.o_set   !== 1'b1)  begin miscompares++; $display("FAIL load_hold_set: got %b expected 1", bif.o_set); end
    @(negedge clk);
    vectors += 5;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL exit_state: got %b expected 00", bif.o_state); end
    if (bif.o_set   !== 1'b0)  begin miscompares++; $display("FAIL exit_set: got %b expected 0", bif.o_set); end
    if (bif.o_pause !== 1'b1)  begin miscompares++; $display("FAIL exit_pause: got %b expected 1", bif.o_pause); end
    if (bif.o_count !== 1'b1)  begin miscompares++; $display("FAIL exit_count: got %b expected 1", bif.o_count); end
    if (bif.o_busy  !== 1'b0)  begin miscompares++; $display("FAIL exit_busy: got %b expected 0", bif.o_busy); end
  endtask

  task automatic test_run_debounce();
    @(posedge clk);
    #1 btn[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL bounce_reject: got %b expected 00", bif.o_state); end
    @(posedge clk);
    #1 btn[0] = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL run_early: got %b expected 00 after 7 clocks", bif.o_state); end
    @(negedge clk);
    vectors += 2;
    if (bif.o_state !== 2'b01) begin miscompares++; $display("FAIL run_latency: got %b expected 01 after 8 clocks", bif.o_state); end
    if (bif.o_pause !== 1'b0)  begin miscompares++; $display("FAIL run_pause: got %b expected 0", bif.o_pause); end
    repeat (2) @(posedge clk);
    #1 btn[0] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_run_load_same();
    @(posedge clk);
    #1 btn = 4'b0011;
    repeat (8) @(negedge clk);
    vectors++;
    if (bif.o_state !== 2'b01) begin miscompares++; $display("FAIL both_early: got %b expected 01", bif.o_state); end
    @(negedge clk);
    vectors += 3;
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL both_load_wins: got %b expected 10", bif.o_state); end
    if (bif.o_set   !== 1'b1)  begin miscompares++; $display("FAIL both_set: got %b expected 1", bif.o_set); end
    if (bif.o_busy  !== 1'b1)  begin miscompares++; $display("FAIL both_busy: got %b expected 1", bif.o_busy); end
    repeat (2) @(posedge clk);
    #1 btn = 4'b0000;
    wait_tick();
    vectors++;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL both_exit: got %b expected 00", bif.o_state); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_toggle_in_load();
    tick_en = 1'b0;
    press_btns(4'b0010);
    vectors++;
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL tl_enter: got %b expected 10", bif.o_state); end
    press_btns(4'b1000);
    vectors += 3;
    if (bif.o_type  !== 1'b1)  begin miscompares++; $display("FAIL tl_disp_type: got %b expected 1", bif.o_type); end
    if (bif.o_count !== 1'b1)  begin miscompares++; $display("FAIL tl_disp_count: got %b expected 1", bif.o_count); end
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL tl_disp_state: got %b expected 10", bif.o_state); end
    press_btns(4'b0100);
    vectors += 3;
    if (bif.o_count !== 1'b0)  begin miscompares++; $display("FAIL tl_mode_count: got %b expected 0", bif.o_count); end
    if (bif.o_type  !== 1'b1)  begin miscompares++; $display("FAIL tl_mode_type: got %b expected 1", bif.o_type); end
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL tl_mode_state: got %b expected 10", bif.o_state); end
    tick_en = 1'b1;
    wait_tick();
    vectors += 3;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL tl_exit_state: got %b expected 00", bif.o_state); end
    if (bif.o_set   !== 1'b0)  begin miscompares++; $display("FAIL tl_exit_set: got %b expected 0", bif.o_set); end
    if (bif.o_pause !== 1'b1)  begin miscompares++; $display("FAIL tl_exit_pause: got %b expected 1", bif.o_pause); end
  endtask

  task automatic test_auto_demo();
    logic exp_count;
    press_btns(4'b0001);
    vectors++;
    if (bif.o_state !== 2'b01) begin miscompares++; $display("FAIL demo_run: got %b expected 01", bif.o_state); end
    wait_tick();
    auto_en   = 1'b1;
    exp_count = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      wait_tick();
      if (t == 4 || t == 8) exp_count = ~exp_count;
      vectors++;
      if (bif.o_count !== exp_count) begin
        miscompares++;
        $display("FAIL demo_tick%0d: got %b expected %b", t, bif.o_count, exp_count);
      end
    end
    auto_en = 1'b0;
    repeat (2) @(negedge clk);
    auto_en = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      wait_tick();
      if (t == 4) exp_count = ~exp_count;
      vectors++;
      if (bif.o_count !== exp_count) begin
        miscompares++;
        $display("FAIL demo_fresh%0d: got %b expected %b", t, bif.o_count, exp_count);
      end
    end
    auto_en = 1'b0;
    press_btns(4'b0001);
    vectors++;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL demo_pause: got %b expected 00", bif.o_state); end
  endtask

  task automatic test_reset_mid_run();
    press_btns(4'b0001);
    wait_tick();
    auto_en = 1'b1;
    repeat (6) wait_tick();
    vectors++;
    if (bif.o_count !== 1'b0) begin miscompares++; $display("FAIL mid_count: got %b expected 0", bif.o_count); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors += 7;
    if (bif.o_state !== 2'b10) begin miscompares++; $display("FAIL mid_rst_state: got %b expected 10", bif.o_state); end
    if (bif.o_set   !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_set: got %b expected 1", bif.o_set); end
    if (bif.o_pause !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_pause: got %b expected 1", bif.o_pause); end
    if (bif.o_busy  !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 1", bif.o_busy); end
    if (bif.o_count !== 1'b1)  begin miscompares++; $display("FAIL mid_rst_count: got %b expected 1", bif.o_count); end
    if (bif.o_type  !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_type: got %b expected 0", bif.o_type); end
    if (dut.demo_cnt !== '0)   begin miscompares++; $display("FAIL mid_rst_demo: got %0d expected 0", dut.demo_cnt); end
    auto_en = 1'b0;
    wait_tick();
    vectors++;
    if (bif.o_state !== 2'b00) begin miscompares++; $display("FAIL mid_exit: got %b expected 00", bif.o_state); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    btn         = 4'b0000;
    auto_en     = 1'b0;
    tick_en     = 1'b0;
    rst_n       = 1'b0;
    test_reset();
    test_run_debounce();
    test_run_load_same();
    test_toggle_in_load();
    test_auto_demo();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
